rcla14_join_stage: RTL and testbench

Stream front-end and back-end for the 14-bit ripple-block carry look-ahead adder (UBRCL_13_0_13_0).
- Joins two independent operand streams (X and Y), each with valid/ready, and presents one operand pair per cycle to the combinational adder core.
- Captures each 15-bit sum into a small output FIFO drained by a valid/ready consumer.
- Converts the purely combinational adder into a back-pressured pipeline stage.

---
 rtl/rcla14_join_stage_pkg.sv | 34 +++
 rtl/rcla14_join_stage_if.sv | 36 +++
 rtl/UBRCL_13_0_13_0.sv | 35 +++
 rtl/rcla14_sum_fifo.sv | 70 +++++++
 rtl/rcla14_join_stage.sv | 113 +++++++++++
 tb/tb_rcla14_join_stage.sv | 293 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/rcla14_join_stage_pkg.sv
// Shared definitions for the rcla14 join stage.
//   OPW / SW      : operand width and sum width (sum carries the carry-out)
//   hold_state_e  : per-channel operand holding register state
//   join_dbg_t    : debug view of both holding-register states
//   clog2()       : pointer width for the output FIFO
package rcla14_join_stage_pkg;

    localparam int OPW = 14;
    localparam int SW  = OPW + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_e;

    typedef struct packed {
        hold_state_e x_state;
        hold_state_e y_state;
    } join_dbg_t;

    // Ceiling log2 for elaboration-time constants (value >= 2).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rcla14_join_stage_if.sv
// Stream bundle for the rcla14 join stage.
//   x_valid/x_ready/x_data : X operand stream (into the stage)
//   y_valid/y_ready/y_data : Y operand stream (into the stage)
//   s_valid/s_ready/s_data : sum stream (out of the stage)
//
// Handshake: a beat transfers on a rising clk edge where valid & ready are
// both high. A producer holding valid keeps its data stable until the
// transfer; ready may depend combinationally on registered state but never
// on the same channel's valid.
//
// master = the environment (drives operands, consumes sums)
// slave  = the join stage
interface rcla14_join_stage_if;
    import rcla14_join_stage_pkg::*;

    logic           x_valid;
    logic           x_ready;
    logic [OPW-1:0] x_data;
    logic           y_valid;
    logic           y_ready;
    logic [OPW-1:0] y_data;
    logic           s_valid;
    logic           s_ready;
    logic [SW-1:0]  s_data;

    modport master (
        output x_valid, x_data, y_valid, y_data, s_ready,
        input  x_ready, y_ready, s_valid, s_data
    );

    modport slave (
        input  x_valid, x_data, y_valid, y_data, s_ready,
        output x_ready, y_ready, s_valid, s_data
    );

endinterface

// File: rtl/UBRCL_13_0_13_0.sv
// 14-bit unsigned adder, ripple-block carry look-ahead, carry-in tied to 0.
//   X, Y : 14-bit operands
//   S    : 15-bit sum, carry-out in S[14]
// Bits are grouped into blocks [3:0], [7:4], [11:8], [13:12]. Inside a block
// every carry is a look-ahead expression of the block carry-in; the block
// carry-out then ripples into the next block.
module UBRCL_13_0_13_0 (
    input  logic [13:0] X,
    input  logic [13:0] Y,
    output logic [14:0] S
);

    logic [13:0] g;
    logic [13:0] p;
    logic [14:0] c;
    logic        acc;

    always_comb begin
        g   = X & Y;
        p   = X ^ Y;
        c   = '0;
        acc = 1'b0;
        for (int i = 0; i < 14; i++) begin
            // Start from this bit's block carry-in and expand generate/propagate
            // terms across the block up to bit i.
            acc = c[(i / 4) * 4];
            for (int k = (i / 4) * 4; k <= i; k++) begin
                acc = g[k] | (p[k] & acc);
            end
            c[i + 1] = acc;
        end
        S = {c[14], p ^ c[13:0]};
    end

endmodule

// File: rtl/rcla14_sum_fifo.sv
// Synchronous DEPTH x SW FIFO holding adder results.
//   push/wdata : write tail (ignored when full unless popping the same cycle)
//   pop        : release head (ignored when empty)
//   rdata      : head entry; while empty, the last value popped (0 after reset)
//   full/empty/count : occupancy
module rcla14_sum_fifo
    import rcla14_join_stage_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [SW-1:0] wdata,
    output logic [SW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [SW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [SW-1:0] last_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    // Outputs only ever come from registers: a stored entry or the last pop.
    assign rdata = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/rcla14_join_stage.sv
// Back-pressured pipeline stage around the 14-bit RCLA adder.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : X/Y operand streams in, sum stream out (slave modport)
//   pair_cnt   : pairs written to the sum FIFO since reset (wraps)
//   busy       : a holding register or FIFO entry is occupied
//   dbg        : holding-register states of both channels
// Each channel owns one holding register. When both are FULL and the FIFO
// can take a result (not full, or its head leaves this cycle) the pair fires:
// the adder sees both holds and its sum is pushed. A firing hold is free to
// reload in the same cycle, giving one pair per clock at full throughput.
module rcla14_join_stage
    import rcla14_join_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rcla14_join_stage_if.slave     bus,
    output logic [CNT_W-1:0]       pair_cnt,
    output logic                   busy,
    output join_dbg_t              dbg
);

    localparam int AW = clog2(DEPTH);

    hold_state_e    x_state;
    hold_state_e    y_state;
    logic [OPW-1:0] x_hold;
    logic [OPW-1:0] y_hold;
    logic           x_hold_vld;
    logic           y_hold_vld;
    logic           x_accept;
    logic           y_accept;
    logic           fire;
    logic           pop;
    logic [SW-1:0]  sum;
    logic [SW-1:0]  fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic [AW:0]    fifo_count;

    assign x_hold_vld = (x_state == FULL);
    assign y_hold_vld = (y_state == FULL);

    assign pop  = ~fifo_empty & bus.s_ready;
    assign fire = x_hold_vld & y_hold_vld & (~fifo_full | pop);

    assign bus.x_ready = ~x_hold_vld | fire;
    assign bus.y_ready = ~y_hold_vld | fire;
    assign x_accept    = bus.x_valid & bus.x_ready;
    assign y_accept    = bus.y_valid & bus.y_ready;

    assign bus.s_valid = ~fifo_empty;
    assign bus.s_data  = fifo_rdata;

    assign busy = x_hold_vld | y_hold_vld | (fifo_count != '0);
    assign dbg  = '{x_state: x_state, y_state: y_state};

    // Input data is captured only on accept and stays frozen while FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_state <= EMPTY;
            x_hold  <= '0;
        end else if (x_accept) begin
            x_state <= FULL;
            x_hold  <= bus.x_data;
        end else if (fire) begin
            x_state <= EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_state <= EMPTY;
            y_hold  <= '0;
        end else if (y_accept) begin
            y_state <= FULL;
            y_hold  <= bus.y_data;
        end else if (fire) begin
            y_state <= EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt <= '0;
        end else if (fire) begin
            pair_cnt <= pair_cnt + 1'b1;
        end
    end

    UBRCL_13_0_13_0 u_adder (
        .X (x_hold),
        .Y (y_hold),
        .S (sum)
    );

    rcla14_sum_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fire),
        .pop   (pop),
        .wdata (sum),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_rcla14_join_stage.sv
module tb_rcla14_join_stage;
    import rcla14_join_stage_pkg::*;

    localparam int DEPTH = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rcla14_join_stage_if bus ();
    rcla14_join_stage_if bus4 ();

    logic [15:0] pair_cnt;
    logic [3:0]  pair_cnt4;
    logic        busy;
    logic        busy4;
    join_dbg_t   dbg;
    join_dbg_t   dbg4;

    rcla14_join_stage #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .pair_cnt (pair_cnt),
        .busy     (busy),
        .dbg      (dbg)
    );

    // Narrow-counter copy fed with identical stimulus, used for the wrap check.
    assign bus4.x_valid = bus.x_valid;
    assign bus4.x_data  = bus.x_data;
    assign bus4.y_valid = bus.y_valid;
    assign bus4.y_data  = bus.y_data;
    assign bus4.s_ready = bus.s_ready;

    rcla14_join_stage #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus4),
        .pair_cnt (pair_cnt4),
        .busy     (busy4),
        .dbg      (dbg4)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / model ----------------
    // Transaction view: operands accepted but not yet paired, sums queued.
    logic [13:0] xq[$];
    logic [13:0] yq[$];
    logic [14:0] exp_q[$];
    logic [14:0] obs[$];
    logic [14:0] m_last;
    int          mcnt;
    bit          pop_m, fire_m, xr_m, yr_m;

    always @(negedge clk) begin
        if (!rst_n) begin
            xq.delete();
            yq.delete();
            exp_q.delete();
            mcnt   = 0;
            m_last = '0;
        end else begin
            pop_m  = (exp_q.size() > 0) && bus.s_ready;
            fire_m = (xq.size() > 0) && (yq.size() > 0) && ((exp_q.size() < DEPTH) || pop_m);
            xr_m   = (xq.size() == 0) || fire_m;
            yr_m   = (yq.size() == 0) || fire_m;
            check("m_x_ready", bus.x_ready, xr_m);
            check("m_y_ready", bus.y_ready, yr_m);
            check("m_s_valid", bus.s_valid, exp_q.size() > 0);
            check("m_s_data", bus.s_data, (exp_q.size() > 0) ? exp_q[0] : m_last);
            check("m_busy", busy, (xq.size() + yq.size() + exp_q.size()) != 0);
            check("m_pair_cnt", pair_cnt, mcnt[15:0]);
            check("m_pair_cnt4", pair_cnt4, mcnt[3:0]);
            if (pop_m) begin
                obs.push_back(exp_q[0]);
                m_last = exp_q[0];
                void'(exp_q.pop_front());
            end
            if (fire_m) begin
                exp_q.push_back({1'b0, xq[0]} + {1'b0, yq[0]});
                void'(xq.pop_front());
                void'(yq.pop_front());
                mcnt++;
            end
            if (bus.x_valid && xr_m) xq.push_back(bus.x_data);
            if (bus.y_valid && yr_m) yq.push_back(bus.y_data);
        end
    end

    // ---------------- driver tasks ----------------
    // Offers one operand on each channel; each channel drops valid once taken.
    task automatic send_pair(input logic [13:0] xd, input logic [13:0] yd);
        bit x_done, y_done, xa, ya;
        int n;
        x_done = 0;
        y_done = 0;
        n = 0;
        bus.x_valid = 1'b1;
        bus.x_data  = xd;
        bus.y_valid = 1'b1;
        bus.y_data  = yd;
        while (!(x_done && y_done)) begin
            @(negedge clk);
            xa = bus.x_valid && bus.x_ready;
            ya = bus.y_valid && bus.y_ready;
            @(posedge clk);
            #1;
            if (xa) begin x_done = 1; bus.x_valid = 1'b0; end
            if (ya) begin y_done = 1; bus.y_valid = 1'b0; end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_pair: no accept within 200 cycles (x=0x%0h y=0x%0h)", xd, yd);
                bus.x_valid = 1'b0;
                bus.y_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [13:0] bp_x[4] = '{14'h0001, 14'h0003, 14'h0005, 14'h0007};
    logic [13:0] bp_y[4] = '{14'h0002, 14'h0004, 14'h0006, 14'h0008};
    bit bp_done;

    // ---------------- stimulus ----------------
    initial begin
        bus.x_valid = 1'b0;
        bus.x_data  = '0;
        bus.y_valid = 1'b0;
        bus.y_data  = '0;
        bus.s_ready = 1'b1;

        // Reset state
        #12;
        check("rst_s_valid", bus.s_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pair_cnt", pair_cnt, 0);
        check("rst_s_data", bus.s_data, 0);
        check("rst_x_ready", bus.x_ready, 1);
        check("rst_y_ready", bus.y_ready, 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick(1);

        // Back-to-back pairs, consumer always ready
        obs.delete();
        send_pair(14'h1234, 14'h0DCB);
        check("lat_not_yet", bus.s_valid, 0);
        send_pair(14'h3FFF, 14'h3FFF);
        check("lat_valid", bus.s_valid, 1);
        check("b2b_head0", bus.s_data, 15'h1FFF);
        send_pair(14'h0FFF, 14'h0001);
        check("b2b_head1", bus.s_data, 15'h7FFE);
        tick(4);
        check("b2b_count", obs.size(), 3);
        if (obs.size() == 3) begin
            check("b2b_out0", obs[0], 15'h1FFF);
            check("b2b_out1", obs[1], 15'h7FFE);
            check("b2b_out2", obs[2], 15'h1000);
        end
        check("b2b_pair_cnt", pair_cnt, 3);

        // Skewed arrival: X early, Y five cycles later
        bus.x_valid = 1'b1;
        bus.x_data  = 14'h0005;
        tick(1);
        bus.x_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("skew_x_blocked", bus.x_ready, 0);
            check("skew_y_open", bus.y_ready, 1);
            tick(1);
        end
        bus.y_valid = 1'b1;
        bus.y_data  = 14'h000A;
        check("skew_x_blocked5", bus.x_ready, 0);
        tick(1);
        bus.y_valid = 1'b0;
        check("skew_fire_ready", bus.x_ready, 1);
        check("skew_not_yet", bus.s_valid, 0);
        tick(1);
        check("skew_valid", bus.s_valid, 1);
        check("skew_sum", bus.s_data, 15'h000F);
        tick(2);

        // Back-pressure: four pairs with the consumer stalled
        obs.delete();
        bus.s_ready = 1'b0;
        bp_done = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_pair(bp_x[i], bp_y[i]);
                bp_done = 1;
            end
        join_none
        tick(10);
        check("bp_s_valid", bus.s_valid, 1);
        check("bp_x_ready", bus.x_ready, 0);
        check("bp_y_ready", bus.y_ready, 0);
        check("bp_x_hold", dbg.x_state, FULL);
        check("bp_y_hold", dbg.y_state, FULL);
        check("bp_head", bus.s_data, 15'h0003);
        check("bp_pair_cnt", pair_cnt, 6);
        // Full FIFO with a pending pair: pop and push in one edge
        bus.s_ready = 1'b1;
        tick(1);
        check("pp_head", bus.s_data, 15'h0007);
        check("pp_pair_cnt", pair_cnt, 7);
        check("pp_s_valid", bus.s_valid, 1);
        for (int n = 0; n < 100 && !bp_done; n++) @(posedge clk);
        #1;
        check("bp_driver_done", bp_done, 1);
        tick(6);
        check("bp_count", obs.size(), 4);
        if (obs.size() == 4) begin
            check("bp_out0", obs[0], 15'h0003);
            check("bp_out1", obs[1], 15'h0007);
            check("bp_out2", obs[2], 15'h000B);
            check("bp_out3", obs[3], 15'h000F);
        end

        // Reset mid-stream: two sums queued, X held
        bus.s_ready = 1'b0;
        send_pair(14'h0010, 14'h0020);
        send_pair(14'h0030, 14'h0040);
        bus.x_valid = 1'b1;
        bus.x_data  = 14'h0111;
        tick(1);
        bus.x_valid = 1'b0;
        tick(2);
        check("pre_rst_pair_cnt", pair_cnt, 10);
        check("pre_rst_x_hold", dbg.x_state, FULL);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_s_valid", bus.s_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pair_cnt", pair_cnt, 0);
        check("mid_rst_s_data", bus.s_data, 0);
        check("mid_rst_x_ready", bus.x_ready, 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        obs.delete();
        bus.s_ready = 1'b1;
        tick(1);
        send_pair(14'h0100, 14'h0023);
        tick(4);
        check("post_rst_count", obs.size(), 1);
        if (obs.size() == 1) check("post_rst_sum", obs[0], 15'h0123);
        check("post_rst_pair_cnt", pair_cnt, 1);

        // Counter wrap on the 4-bit copy: 17 pairs from reset
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 17; i++) begin
            send_pair(14'(i * 3 + 1), 14'(i * 5 + 2));
        end
        tick(4);
        check("wrap_cnt4", pair_cnt4, 1);
        check("wrap_cnt16", pair_cnt, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
